// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator with sub-word read-modify-write
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word requests trap instead of being forced aligned)
module load_store_unit #(
  parameter int D_W   = 32,
  parameter int AD_W  = 32,
  parameter int DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [31:0]     req_addr,
  input  logic [D_W-1:0]  req_wdata,
  output logic            resp_valid,
  output logic [D_W-1:0]  resp_rdata,
  output logic            misalign,
  output logic            dm_memread,
  output logic            dm_mem_write,
  output logic [AD_W-1:0] mem_address,
  output logic [D_W-1:0]  dm_data_input,
  input  logic [D_W-1:0]  dm_Memory_out_Data
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR
  } state_t;

  state_t      state;
  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_lo;
  logic [15:0] lat_wdata;

  logic [IDX_W-1:0] word_idx;
  logic             req_misaligned;
  logic             unused_addr_hi;

  // Word index wraps modulo DEPTH; the high address bits are deliberately dropped
  assign word_idx       = req_addr[IDX_W+1:2];
  assign unused_addr_hi = ^req_addr[31:IDX_W+2];

  // Requests are only taken in IDLE, and never while reset is asserted
  assign req_ready = (state == S_IDLE) && !rst;

`ifdef MISALIGN_TRAP_EN
  assign req_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                          (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  // Offending low bits are simply ignored by the lane logic, so nothing traps
  assign req_misaligned = 1'b0;
`endif

  // Pick the addressed lane(s) out of a little-endian word and extend to 32 bits
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lo,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte/half of the word read back from memory
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [15:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lo);
    logic [31:0] mask;
    logic [31:0] data;
    logic [4:0]  sh;
    if (size == 2'b00) begin
      sh   = {lo, 3'b000};
      mask = 32'h0000_00FF << sh;
      data = {24'h0, wd[7:0]} << sh;
    end else begin
      sh   = {lo[1], 4'b0000};
      mask = 32'h0000_FFFF << sh;
      data = {16'h0, wd} << sh;
    end
    return (old_word & ~mask) | (data & mask);
  endfunction

  // Control FSM; every memory-side and response output is a register of this block
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      misalign      <= 1'b0;
      dm_memread    <= 1'b0;
      dm_mem_write  <= 1'b0;
      mem_address   <= '0;
      dm_data_input <= '0;
      lat_write     <= 1'b0;
      lat_size      <= 2'b00;
      lat_unsigned  <= 1'b0;
      lat_lo        <= 2'b00;
      lat_wdata     <= '0;
    end else begin
      // Strobes and the response are single-cycle pulses unless re-asserted below
      resp_valid   <= 1'b0;
      misalign     <= 1'b0;
      dm_memread   <= 1'b0;
      dm_mem_write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_write    <= req_write;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_lo       <= req_addr[1:0];
            lat_wdata    <= req_wdata[15:0];
            mem_address  <= AD_W'(word_idx);
            if (req_misaligned) begin
              // Trapped request: answer immediately, memory is never touched
              resp_valid <= 1'b1;
              misalign   <= 1'b1;
              resp_rdata <= '0;
              state      <= S_IDLE;
            end else if (req_write && req_size[1]) begin
              // Full-word store needs no read-back
              dm_mem_write  <= 1'b1;
              dm_data_input <= req_wdata;
              state         <= S_WR;
            end else begin
              dm_memread <= 1'b1;
              state      <= S_RD;
            end
          end
        end
        S_RD: begin
          // Memory registers the read on this edge; data is present during CAP
          state <= S_CAP;
        end
        S_CAP: begin
          if (lat_write) begin
            dm_data_input <= store_merge(dm_Memory_out_Data, lat_wdata, lat_size, lat_lo);
            dm_mem_write  <= 1'b1;
            state         <= S_WR;
          end else begin
            resp_rdata <= load_extract(dm_Memory_out_Data, lat_size, lat_lo, lat_unsigned);
            resp_valid <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_WR: begin
          resp_rdata <= '0;
          resp_valid <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
